// File: rtl/multi_freq_meter.sv
// Multi-channel frequency / period meter: counts rising edges per gate window or
// clk cycles between rising edges, with saturation reporting, result hold and valid strobes.
module multi_freq_meter #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 20,
    parameter int GATE_CYCLES = 100_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       s,
    input  logic                      mode,
    input  logic                      hold,
    output logic [CHANNELS*CNT_W-1:0] result,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       ovf
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic {ARM, MEAS} state_t;

    logic [CHANNELS-1:0]       sync1, sync2, sync3, rise;
    logic                      mode_q, abort, terminal;
    logic [GATE_W-1:0]         gate_cnt, gate_nxt;
    logic [CNT_W-1:0]          cnt       [CHANNELS];
    logic [CNT_W-1:0]          cnt_nxt   [CHANNELS];
    logic [CNT_W-1:0]          cnt_inc   [CHANNELS];
    state_t                    state     [CHANNELS];
    state_t                    state_nxt [CHANNELS];
    logic [CHANNELS-1:0]       sat, wovf, wovf_nxt;
    logic [CHANNELS*CNT_W-1:0] result_nxt;
    logic [CHANNELS-1:0]       valid_nxt, ovf_nxt;

    // sync3 exists only to detect the rising edge of the synchronised input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= s;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise     = sync2 & ~sync3;
    assign abort    = (mode != mode_q);
    assign terminal = !mode_q && (gate_cnt == GATE_LAST);

    // sat marks an edge that arrives while the counter is already pinned at full scale
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sat[i]     = rise[i] && (cnt[i] == CNT_MAX);
            cnt_inc[i] = (rise[i] && !sat[i]) ? cnt[i] + CNT_ONE : cnt[i];
        end
    end

    always_comb begin
        gate_nxt   = gate_cnt;
        wovf_nxt   = wovf;
        result_nxt = result;
        ovf_nxt    = ovf;
        valid_nxt  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i]   = cnt[i];
            state_nxt[i] = state[i];
        end

        if (abort) begin
            gate_nxt = '0;
            wovf_nxt = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_nxt[i]   = '0;
                state_nxt[i] = ARM;
            end
        end else if (!mode_q) begin
            gate_nxt = terminal ? '0 : gate_cnt + GATE_ONE;
            for (int i = 0; i < CHANNELS; i++) begin
                if (terminal) begin
                    cnt_nxt[i]  = '0;
                    wovf_nxt[i] = 1'b0;
                    if (!hold) begin
                        result_nxt[i*CNT_W +: CNT_W] = cnt_inc[i];
                        ovf_nxt[i]                   = wovf[i] | sat[i];
                        valid_nxt[i]                 = 1'b1;
                    end
                end else begin
                    cnt_nxt[i]  = cnt_inc[i];
                    wovf_nxt[i] = wovf[i] | sat[i];
                end
            end
        end else begin
            // An edge in MEAS takes priority over the timeout on the same cycle
            for (int i = 0; i < CHANNELS; i++) begin
                case (state[i])
                    ARM: begin
                        if (rise[i]) begin
                            cnt_nxt[i]   = CNT_ONE;
                            state_nxt[i] = MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise[i]) begin
                            cnt_nxt[i] = CNT_ONE;
                            if (!hold) begin
                                result_nxt[i*CNT_W +: CNT_W] = cnt[i];
                                ovf_nxt[i]                   = 1'b0;
                                valid_nxt[i]                 = 1'b1;
                            end
                        end else if (cnt[i] == CNT_MAX) begin
                            cnt_nxt[i]   = '0;
                            state_nxt[i] = ARM;
                            if (!hold) begin
                                result_nxt[i*CNT_W +: CNT_W] = CNT_MAX;
                                ovf_nxt[i]                   = 1'b1;
                                valid_nxt[i]                 = 1'b1;
                            end
                        end else begin
                            cnt_nxt[i] = cnt[i] + CNT_ONE;
                        end
                    end
                    default: state_nxt[i] = ARM;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= ARM;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= state_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            gate_cnt <= '0;
            wovf     <= '0;
            result   <= '0;
            valid    <= '0;
            ovf      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            mode_q   <= mode;
            gate_cnt <= gate_nxt;
            wovf     <= wovf_nxt;
            result   <= result_nxt;
            valid    <= valid_nxt;
            ovf      <= ovf_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_freq_meter.sv
// Randomised phase-based bench for multi_freq_meter: expected strobes are derived from
// planned edge times per window / per edge pair and checked by a per-channel scoreboard.
module tb_multi_freq_meter;

    localparam int CH   = 2;
    localparam int CW   = 8;
    localparam int G    = 600;
    localparam int MAXV = (1 << CW) - 1;
    localparam int MAXL = 2000;

    typedef struct {
        int t;
        int r;
        bit o;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] s     = '0;
    logic          mode  = 1'b0;
    logic          hold  = 1'b0;
    logic [CH*CW-1:0] result;
    logic [CH-1:0]    valid;
    logic [CH-1:0]    ovf;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   started     = 1'b0;
    exp_t expQ [CH][$];
    exp_t monE;
    bit   planS [CH][MAXL];
    bit   planH [MAXL];
    bit   modeQ    = 1'b0;
    int   winStart = 0;
    bit   lastS   [CH];
    int   lastRes [CH];
    bit   lastOvf [CH];

    multi_freq_meter #(
        .CHANNELS    (CH),
        .CNT_W       (CW),
        .GATE_CYCLES (G)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s      (s),
        .mode   (mode),
        .hold   (hold),
        .result (result),
        .valid  (valid),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising clk edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void pushExp(input int ch, input int t, input int r, input bit o);
        exp_t e;
        e.t = t;
        e.r = r;
        e.o = o;
        expQ[ch].push_back(e);
        lastRes[ch] = r;
        lastOvf[ch] = o;
    endfunction

    function automatic void fillPeriodic(input int ch, input int len, input int per, input int off);
        for (int k = 0; k < len; k++) planS[ch][k] = (((k + off) % per) < (per / 2));
    endfunction

    function automatic void fillHold(input int len, input int from, input int upto);
        for (int k = 0; k < len; k++) planH[k] = (k >= from) && (k < upto);
    endfunction

    // Plans one constant-mode phase: derive expected strobes from edge times, then drive it
    task automatic applyStimulus(input bit m, input int len);
        int p;
        int n;
        int a;
        bit prev;
        bit armed;
        int evs[$];
        @(negedge clk);
        p = cyc + 1;
        for (int i = 0; i < CH; i++) begin
            checkOutput($sformatf("retained_result_ch%0d", i), int'(result[i*CW +: CW]), lastRes[i]);
            checkOutput($sformatf("retained_ovf_ch%0d", i), int'(ovf[i]), int'(lastOvf[i]));
        end
        if (m != modeQ) winStart = p;
        for (int i = 0; i < CH; i++) begin
            for (int k = len - 4; k < len; k++) planS[i][k] = 1'b0;
            evs.delete();
            prev = lastS[i];
            for (int k = 0; k < len; k++) begin
                if (planS[i][k] && !prev) evs.push_back(p + k + 2);
                prev = planS[i][k];
            end
            lastS[i] = prev;
            if (!m) begin
                for (int t = winStart + G; t <= p + len - 1; t += G) begin
                    if (t >= p && !planH[t - p]) begin
                        n = 0;
                        foreach (evs[j]) if (evs[j] > t - G && evs[j] <= t) n++;
                        pushExp(i, t, (n > MAXV) ? MAXV : n, n > MAXV);
                    end
                end
            end else begin
                armed = 1'b0;
                a = 0;
                foreach (evs[j]) begin
                    if (armed && (evs[j] - a) > MAXV) begin
                        if (!planH[a + MAXV - p]) pushExp(i, a + MAXV, MAXV, 1'b1);
                        armed = 1'b0;
                    end
                    if (armed && !planH[evs[j] - p]) pushExp(i, evs[j], evs[j] - a, 1'b0);
                    a = evs[j];
                    armed = 1'b1;
                end
                if (armed && (a + MAXV) <= (p + len - 1) && !planH[a + MAXV - p])
                    pushExp(i, a + MAXV, MAXV, 1'b1);
            end
        end
        modeQ = m;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < CH; i++) s[i] = planS[i][k];
            mode = m;
            hold = planH[k];
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < CH; i++)
            checkOutput($sformatf("reset_result_ch%0d", i), int'(result[i*CW +: CW]), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_ovf", int'(ovf), 0);
        s = '0;
        mode = 1'b0;
        hold = 1'b0;
        modeQ = 1'b0;
        winStart = 0;
        for (int i = 0; i < CH; i++) begin
            lastS[i] = 1'b0;
            lastRes[i] = 0;
            lastOvf[i] = 1'b0;
        end
        started = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending expectation of its channel
    initial begin
        forever begin
            @(negedge clk);
            if (started && rst_n === 1'b1) begin
                for (int i = 0; i < CH; i++) begin
                    if (valid[i] !== 1'b0) begin
                        if (expQ[i].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("[TB] FAIL unexpected_valid_ch%0d: got strobe at cycle %0d, expected none", i, cyc);
                        end else begin
                            monE = expQ[i].pop_front();
                            checkOutput($sformatf("valid_cycle_ch%0d", i), cyc, monE.t);
                            checkOutput($sformatf("result_ch%0d", i), int'(result[i*CW +: CW]), monE.r);
                            checkOutput($sformatf("ovf_ch%0d", i), int'(ovf[i]), int'(monE.o));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        int h0;
        doReset();

        fillHold(1830, 0, 0);
        fillPeriodic(0, 1830, 10, $urandom_range(0, 9));
        fillPeriodic(1, 1830, 25, $urandom_range(0, 24));
        applyStimulus(1'b0, 1830);

        fillHold(1500, 0, 0);
        fillPeriodic(0, 1500, 37, $urandom_range(0, 36));
        fillPeriodic(1, 1500, 200, $urandom_range(0, 199));
        applyStimulus(1'b1, 1500);

        fillHold(1230, 0, 0);
        fillPeriodic(0, 1230, 2, $urandom_range(0, 1));
        fillPeriodic(1, 1230, $urandom_range(3, 40), $urandom_range(0, 40));
        applyStimulus(1'b0, 1230);

        // Lone edge then silence forces a timeout, later edges 50 cycles apart re-arm
        fillHold(1000, 0, 0);
        fillPeriodic(0, 1000, 2000, 1000);
        planS[0][5]   = 1'b1;
        planS[0][6]   = 1'b1;
        planS[0][600] = 1'b1;
        planS[0][650] = 1'b1;
        fillPeriodic(1, 1000, $urandom_range(50, 300), $urandom_range(0, 300));
        applyStimulus(1'b1, 1000);

        fillHold(300, 0, 0);
        fillPeriodic(0, 300, 7, 0);
        fillPeriodic(1, 300, 13, 0);
        applyStimulus(1'b0, 300);

        fillHold(40, 0, 0);
        fillPeriodic(0, 40, 100, 0);
        fillPeriodic(1, 40, 100, 50);
        applyStimulus(1'b1, 40);

        fillHold(1830, 0, 1210);
        fillPeriodic(0, 1830, $urandom_range(2, 30), $urandom_range(0, 30));
        fillPeriodic(1, 1830, $urandom_range(2, 30), $urandom_range(0, 30));
        applyStimulus(1'b0, 1830);

        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(700, 1400);
            h0  = $urandom_range(0, len - 1);
            fillHold(len, h0, h0 + $urandom_range(0, 400));
            fillPeriodic(0, len, $urandom_range(2, 300), $urandom_range(0, 300));
            fillPeriodic(1, len, $urandom_range(2, 300), $urandom_range(0, 300));
            applyStimulus((r % 2) == 0, len);
        end

        fillHold(900, 0, 0);
        fillPeriodic(0, 900, 2, 0);
        fillPeriodic(1, 900, $urandom_range(2, 40), 0);
        applyStimulus(1'b0, 900);
        doReset();

        fillHold(1230, 0, 0);
        fillPeriodic(0, 1230, $urandom_range(2, 40), $urandom_range(0, 40));
        fillPeriodic(1, 1230, $urandom_range(2, 40), $urandom_range(0, 40));
        applyStimulus(1'b0, 1230);

        repeat (5) @(negedge clk);
        for (int i = 0; i < CH; i++)
            checkOutput($sformatf("pending_expectations_ch%0d", i), expQ[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_freq_meter.md
# multi_freq_meter

Parametrised, multi-channel successor to the single-channel frequency and period meters. It measures CHANNELS asynchronous inputs at once, in a selectable mode:
- frequency mode: rising edges per gate window;
- period mode: clk cycles between consecutive rising edges.

It adds saturation/overflow reporting, a result hold, and per-channel valid strobes. Its flattened results feed the binary-to-BCD converter and display path.

## Interface
Parameters:
- CHANNELS, 2, number of measured inputs
- CNT_W, 20, width of each counter and result
- GATE_CYCLES, 100_000_000, frequency-mode gate window in clk cycles (must be ≥ 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s  in  CHANNELS  asynchronous signal inputs, bit i = channel i
- mode  in  1  0 = frequency, 1 = period; synchronous to clk
- hold  in  1  1 = freeze result/ovf and suppress valid; measurement continues
- result  out  CHANNELS*CNT_W  channel i at bits [i*CNT_W +: CNT_W]
- valid  out  CHANNELS  one-cycle strobe: channel i result/ovf just updated
- ovf  out  CHANNELS  channel i's current result is saturated

## Operation
**Input conditioning (per channel)**
- Three flops: sync1, sync2, sync3. All reset to 0.
- edge = sync2 & ~sync3.
- An input already high at reset release counts as one rising edge.

**Mode tracking**
- mode_q registers mode; resets to 0.
- On any cycle with mode != mode_q (the abort cycle), all of the following happen:
  - gate counter, every channel counter, and every channel state are cleared (state → ARM);
  - no valid is generated;
  - result and ovf are retained.

**Frequency mode (mode_q = 0)**
- Global gate_cnt runs 0 to GATE_CYCLES-1, then wraps.
- Per-channel cnt increments on each edge, saturating at 2^CNT_W-1. The saturating increment also sets a window-overflow bit.
- Terminal cycle (gate_cnt = GATE_CYCLES-1):
  - updated value = cnt + edge (saturating);
  - cnt ← 0; window-overflow bit cleared;
  - result_i ← updated value; ovf_i ← window-overflow (including saturation on this cycle); valid_i ← 1.
- All channels update on the same cycle.

**Period mode (mode_q = 1), per-channel FSM**
- ARM:
  - on edge: cnt ← 1, go to MEAS;
  - otherwise hold.
- MEAS, on edge:
  - result_i ← cnt; ovf_i ← 0; valid_i ← 1;
  - cnt ← 1; stay in MEAS.
- MEAS, no edge, cnt < 2^CNT_W-1: cnt ← cnt+1.
- MEAS, no edge, cnt = 2^CNT_W-1 (timeout):
  - result_i ← all ones; ovf_i ← 1; valid_i ← 1;
  - go to ARM.
- Result = number of clk cycles between two detected edges.

**Hold**
- While hold = 1, result, ovf and valid do not update; valid stays 0.
- Counters, gate_cnt and FSMs keep running.
- Updates due during hold are discarded, not queued.

## Timing
**Reset values** (applied asynchronously on rst_n low)
- result = 0, valid = 0, ovf = 0.
- All counters 0, all FSMs ARM, mode_q = 0.

**Latencies**
- s rising to edge: 2–3 clk cycles (synchroniser).
- valid, result and ovf are registered together. They change on the cycle after the terminal/edge/timeout cycle, and valid is high exactly one cycle.

**Frequency-mode windows**
- First valid: at the GATE_CYCLES-th rising clk after reset release, or after an abort cycle.
- Afterwards: one valid every GATE_CYCLES cycles.

**Boundary cases**
- Edge on the terminal cycle is counted in the closing window.
- Edge on the abort cycle is ignored.
- Reset mid-measurement clears everything immediately; no partial result is emitted.
- hold and a result update on the same cycle: the update is suppressed.
- Channels are fully independent in period mode; valid bits may assert on different cycles.
- Result width never exceeds CNT_W; arithmetic saturates, never wraps.

## Test plan
1. CHANNELS=2, GATE_CYCLES=1000, mode=0; ch0 square wave period 10 clk, ch1 period 25 → each valid pulse shows ch0=100 and ch1=40 (±1 for phase), valid=2'b11, ovf=0, pulses 1000 cycles apart.
2. mode=1; ch0 period 37, ch1 period 200 → result0=37 and result1=200 after each channel's second edge, independent valid strobes, ovf=0.
3. CNT_W=8, GATE_CYCLES=1000, mode=0; ch0 period 2 → result0=255, ovf0=1. Then mode=1 with a single edge followed by silence → after 255 cycles result0=255, ovf0=1, one valid, FSM back in ARM; the next two edges 50 cycles apart → 50, ovf0=0.
4. mode=0, switch to mode=1 mid-window then back → no valid during the aborts, result unchanged; first frequency valid exactly GATE_CYCLES cycles after the final abort cycle.
5. mode=0, hold=1 across two windows → no valid, result frozen. Release hold → next terminal produces valid with the fresh count, not a stale one.
6. rst_n pulsed low mid-window, asynchronously to clk → result/valid/ovf read 0 before the next clk edge; after release the first valid arrives GATE_CYCLES cycles later.
